mips_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the next-generation MIPS core; replaces the single-cycle PC register.

---
 rtl/mips_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_mips_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, response FIFO, redirect with stale-response drop.
// Optional FETCH_PERF_EN adds saturating perf_fetched/perf_dropped counters.
module mips_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       PC_STEP    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              req_valid_q, req_valid_d;

  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

  logic req_fire, stale, push, pop, empty;

  assign empty    = (count_q == '0);
  assign req_fire = req_valid_q & imem_req_ready;
  assign stale    = imem_resp_valid & (state_q == DRAIN);
  assign push     = imem_resp_valid & ~stale & ~redirect_valid;
  assign pop      = ~empty & inst_ready & ~redirect_valid;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    drop_d      = drop_q;
    outst_d     = outst_q + CW'(req_fire) - CW'(imem_resp_valid);

    if (redirect_valid) begin
      // Every request still in flight after this edge carries an old address.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (push) begin
        resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (stale) drop_d = drop_q - CW'(1);
    end

    state_d     = (drop_d != '0) ? DRAIN : RUN;
    req_valid_d = (SW'(count_d) + SW'(outst_d)) < SW'(FIFO_DEPTH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Storage is reset so the combinational head reads 0 / RESET_PC out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else if (push) begin
      data_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = ~empty;
  assign inst_data      = data_mem[rd_ptr_q];
  assign inst_pc        = pc_mem[rd_ptr_q];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;
  logic        discard;

  assign discard = imem_resp_valid & ~push;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (push && (perf_fetched_q != '1))    perf_fetched_q <= perf_fetched_q + 32'd1;
      if (discard && (perf_dropped_q != '1)) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a variable-latency imem model and delivered-instruction log.
module tb_mips_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clock = ~clock;

  mips_fetch_unit #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .FIFO_DEPTH(4),
    .PC_STEP   (1),
    .RESET_PC  (32'h0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        q[$];
  req_t        r;
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  int unsigned cyc, lat, nreq, nresp;
  int unsigned nchk, nfail, n0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle, run mid-cycle: present imem response, log accepts and pops, then advance.
  task automatic tick();
    cyc++;
    if (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(r.addr);
      nresp++;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    if (imem_req_valid && imem_req_ready) begin
      q.push_back('{addr: imem_req_addr, due: cyc + lat});
      nreq++;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      got_pc.push_back(inst_pc);
      got_data.push_back(inst_data);
    end
    @(negedge clock);
  endtask

  task automatic clear_model();
    q.delete();
    got_pc.delete();
    got_data.delete();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    nreq  = 0;
    nresp = 0;
  endtask

  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    clear_model();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    nchk = 0; nfail = 0; cyc = 0; lat = 1;
    reset_n         = 1'b0;
    imem_req_ready  = 1'b1;
    inst_ready      = 1'b0;
    redirect_pc     = '0;
    clear_model();

    @(negedge clock);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Latency 1 streaming: in-order delivery and 1/cycle throughput
    apply_reset();
    lat = 1; inst_ready = 1'b1;
    repeat (8) tick();
    n0 = got_pc.size();
    check("t2_fill_pops", n0, 5);
    repeat (12) tick();
    check("t2_throughput", got_pc.size() - n0, 12);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_pc%0d", i), got_pc[i], i);
      check($sformatf("t2_data%0d", i), got_data[i], 32'hA000_0000 + i);
    end

    // Backpressure: credit cap stops issue at 4, then gap-free drain
    apply_reset();
    lat = 1; inst_ready = 1'b0;
    repeat (20) tick();
    check("t3_nreq", nreq, 4);
    check("t3_req_valid_off", imem_req_valid, 0);
    inst_ready = 1'b1;
    repeat (30) tick();
    for (int i = 0; i < 8; i++) check($sformatf("t3_pc%0d", i), got_pc[i], i);
    check("t3_data7", got_data[7], 32'hA000_0007);

    // Latency 3, redirect with 3 requests in flight
    apply_reset();
    lat = 3; inst_ready = 1'b1;
    repeat (3) tick();
    check("t4_pre_addr", imem_req_addr, 2);
    check("t4_pre_valid", imem_req_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("t4_fetch_addr", imem_req_addr, 32'h40);
    repeat (10) tick();
    check("t4_first_pc", got_pc[0], 32'h40);
    check("t4_first_data", got_data[0], 32'hA000_0040);
    check("t4_second_pc", got_pc[1], 32'h41);
`ifdef FETCH_PERF_EN
    check("t4_perf_dropped", perf_dropped, 3);
    check("t4_perf_fetched", perf_fetched, nresp - 3);
`endif

    // Redirect coinciding with pop, push and accept
    apply_reset();
    lat = 1; inst_ready = 1'b1;
    repeat (10) tick();
    check("t5_head_pc", inst_pc, 7);
    check("t5_pre_addr", imem_req_addr, 9);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t5_flushed", inst_valid, 0);
    check("t5_fetch_addr", imem_req_addr, 32'h100);
    repeat (6) tick();
    check("t5_last_old_pc", got_pc[6], 6);
    check("t5_new_pc", got_pc[7], 32'h100);
    check("t5_new_data", got_data[7], 32'hA000_0100);
    check("t5_next_pc", got_pc[8], 32'h101);

    // Reset mid-stream with responses outstanding and words buffered
    apply_reset();
    lat = 2; inst_ready = 1'b0;
    repeat (5) tick();
    check("t1_pre_inst_valid", inst_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_req_valid", imem_req_valid, 0);
    check("t1_inst_valid", inst_valid, 0);
    check("t1_inst_data", inst_data, 0);
    check("t1_inst_pc", inst_pc, 0);
    clear_model();
    @(negedge clock);
    reset_n = 1'b1;
    inst_ready = 1'b1;
    tick();
    check("t1_first_req_valid", imem_req_valid, 1);
    check("t1_first_req_addr", imem_req_addr, 0);
    repeat (10) tick();
    check("t1_first_pc", got_pc[0], 0);
    check("t1_first_data", got_data[0], 32'hA000_0000);
    check("t1_second_pc", got_pc[1], 1);

    // PC wrap at 2^32-1
    apply_reset();
    lat = 1; inst_ready = 1'b1;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("t6_addr_max", imem_req_addr, 32'hFFFF_FFFF);
    check("t6_valid", imem_req_valid, 1);
    tick();
    check("t6_addr_wrap", imem_req_addr, 0);
    repeat (8) tick();
    check("t6_pc_max", got_pc[3], 32'hFFFF_FFFF);
    check("t6_data_max", got_data[3], 32'h9FFF_FFFF);
    check("t6_pc_wrap", got_pc[4], 0);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
